// File: rtl/pie_cmd_if.sv
// Decoder-side and tag-FSM-side signals of the PIE command controller.
// slave: controller view (decoder status in, framed command out); master: driver view.
`timescale 1ns/1ps
interface pie_cmd_if #(
    parameter int BUF_W = 40
);
    logic             rx_en;
    logic             delimiter;
    logic             pie_clk;
    logic             pie_data;
    logic             crc_flg;
    logic             dec_done;
    logic [9:0]       trcal;
    logic             dec_en;
    logic             cmd_end;
    logic [8:0]       tpri_10;
    logic             query_dr;
    logic [BUF_W-1:0] cmd_buf;
    logic [5:0]       cmd_len;
    logic             cmd_valid;
    logic             cmd_err;

    modport master (
        output rx_en, delimiter, pie_clk, pie_data,
        output crc_flg, dec_done, trcal,
        input  dec_en, cmd_end, tpri_10, query_dr,
        input  cmd_buf, cmd_len, cmd_valid, cmd_err
    );

    modport slave (
        input  rx_en, delimiter, pie_clk, pie_data,
        input  crc_flg, dec_done, trcal,
        output dec_en, cmd_end, tpri_10, query_dr,
        output cmd_buf, cmd_len, cmd_valid, cmd_err
    );
endinterface

// File: rtl/pie_cmd_ctrl.sv
// PIE command controller: frames decoded bits into one EPC Gen2 command.
// Ports: clk_1_92m, rst_n (async low), bus = pie_cmd_if.slave (decoder + tag FSM).
`timescale 1ns/1ps
module pie_cmd_ctrl #(
    parameter int TIMEOUT = 1500,
    parameter int BUF_W   = 40
) (
    input logic     clk_1_92m,
    input logic     rst_n,
    pie_cmd_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RX, S_END, S_DONE, S_ERR
    } state_t;

    state_t state, state_n;

    logic             delim_in, pclk_in;
    logic             dlm_tog, bit_tog, bit_dat;
    logic [2:0]       dlm_s, bit_s, done_s;
    logic             dlm_ev, bit_ev, done_rise;

    logic [BUF_W-1:0] cmd_buf, buf_n;
    logic [5:0]       bit_cnt, cnt_n, cmd_len, len_new;
    logic [TW-1:0]    timer;
    logic             tmo;
    logic [8:0]       tpri_10, tpri_new;
    logic [15:0]      prod;
    logic             query_dr;
    logic             unres, resolved, is_query, bad_code;
    logic             frame_err, frame_end;
    logic             dec_en, cmd_end, cmd_valid, cmd_err;

    assign delim_in = bus.delimiter;
    assign pclk_in  = bus.pie_clk;

    // Narrow strobes are turned into level toggles in their own domain
    always_ff @(posedge delim_in or negedge rst_n) begin
        if (!rst_n) dlm_tog <= 1'b0;
        else        dlm_tog <= ~dlm_tog;
    end

    always_ff @(posedge pclk_in or negedge rst_n) begin
        if (!rst_n) begin
            bit_tog <= 1'b0;
            bit_dat <= 1'b0;
        end else begin
            bit_tog <= ~bit_tog;
            bit_dat <= bus.pie_data;
        end
    end

    // Sync history keeps running in every state so stale toggles never fire
    always_ff @(posedge clk_1_92m or negedge rst_n) begin
        if (!rst_n) begin
            dlm_s  <= '0;
            bit_s  <= '0;
            done_s <= '0;
        end else begin
            dlm_s  <= {dlm_s[1:0], dlm_tog};
            bit_s  <= {bit_s[1:0], bit_tog};
            done_s <= {done_s[1:0], bus.dec_done};
        end
    end

    assign dlm_ev    = dlm_s[2] ^ dlm_s[1];
    assign bit_ev    = bit_s[2] ^ bit_s[1];
    assign done_rise = done_s[1] & ~done_s[2];

    // Length resolution on the buffer as it will look after this bit
    assign buf_n = {cmd_buf[BUF_W-2:0], bit_dat};
    assign cnt_n = bit_cnt + 6'd1;
    assign unres = (cmd_len == 6'd0);

    always_comb begin
        len_new  = cmd_len;
        resolved = 1'b0;
        is_query = 1'b0;
        bad_code = 1'b0;
        unique case (1'b1)
            unres && cnt_n == 6'd2 && !buf_n[1]: begin
                resolved = 1'b1;
                len_new  = buf_n[0] ? 6'd18 : 6'd4;
            end
            unres && cnt_n == 6'd4 && buf_n[3:2] == 2'b10: begin
                if (buf_n[1]) begin
                    bad_code = 1'b1;
                end else begin
                    resolved = 1'b1;
                    is_query = !buf_n[0];
                    len_new  = buf_n[0] ? 6'd9 : 6'd22;
                end
            end
            unres && cnt_n == 6'd8 && buf_n[7:6] == 2'b11: begin
                if (buf_n[5:1] != 5'd0) begin
                    bad_code = 1'b1;
                end else begin
                    resolved = 1'b1;
                    len_new  = buf_n[0] ? 6'd40 : 6'd8;
                end
            end
            default: ;
        endcase
    end

    // Preamble must be present for Query and absent for everything else
    assign frame_err = bad_code
                     | (resolved && (is_query != bus.crc_flg));
    assign frame_end = (len_new != 6'd0) && (cnt_n == len_new);
    assign tmo       = (timer == TLIM);

    always_ff @(posedge clk_1_92m or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (bus.rx_en) state_n = S_WAIT;
            S_WAIT: begin
                if (!bus.rx_en)  state_n = S_IDLE;
                else if (dlm_ev) state_n = S_RX;
            end
            S_RX: begin
                if (dlm_ev) begin
                    state_n = S_RX;
                end else if (bit_ev) begin
                    if (frame_err)      state_n = S_ERR;
                    else if (frame_end) state_n = S_END;
                end else if (tmo) begin
                    state_n = S_ERR;
                end
            end
            S_END: begin
                if (dlm_ev)         state_n = S_RX;
                else if (bit_ev)    state_n = S_ERR;
                else if (done_rise) state_n = S_DONE;
                else if (tmo)       state_n = S_ERR;
            end
            S_DONE, S_ERR: state_n = bus.rx_en ? S_WAIT : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        dec_en    = 1'b0;
        cmd_end   = 1'b0;
        cmd_valid = 1'b0;
        cmd_err   = 1'b0;
        unique case (state)
            S_WAIT, S_RX: dec_en = 1'b1;
            S_END: begin
                dec_en  = 1'b1;
                cmd_end = 1'b1;
            end
            S_DONE: cmd_valid = 1'b1;
            S_ERR:  cmd_err   = 1'b1;
            default: ;
        endcase
    end

    // Query b4 (DR) sits at bit 17 of a 22-bit frame
    assign prod     = {6'd0, bus.trcal}
                    * (cmd_buf[17] ? 16'd19 : 16'd51);
    assign tpri_new = 9'(prod >> 12);

    always_ff @(posedge clk_1_92m or negedge rst_n) begin
        if (!rst_n) begin
            cmd_buf  <= '0;
            bit_cnt  <= '0;
            cmd_len  <= '0;
            timer    <= '0;
            tpri_10  <= '0;
            query_dr <= 1'b0;
        end else begin
            if (dlm_ev && state_n == S_RX) begin
                cmd_buf <= '0;
                bit_cnt <= '0;
                cmd_len <= '0;
                timer   <= '0;
            end else if (state == S_RX && bit_ev) begin
                cmd_buf <= buf_n;
                bit_cnt <= cnt_n;
                cmd_len <= len_new;
                timer   <= TW'(1);
            end else if (state == S_RX || state == S_END) begin
                if (!tmo) timer <= timer + TW'(1);
            end
            if (state == S_END && state_n == S_DONE
                && cmd_len == 6'd22) begin
                query_dr <= cmd_buf[17];
                tpri_10  <= tpri_new;
            end
        end
    end

    assign bus.dec_en    = dec_en;
    assign bus.cmd_end   = cmd_end;
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_err   = cmd_err;
    assign bus.cmd_buf   = cmd_buf;
    assign bus.cmd_len   = cmd_len;
    assign bus.tpri_10   = tpri_10;
    assign bus.query_dr  = query_dr;

endmodule

// File: tb/tb_pie_cmd_ctrl.sv
// Self-checking bench for pie_cmd_ctrl: directed scenarios plus random frames
// checked against a command-table reference model.
`timescale 1ns/1ps
module tb_pie_cmd_ctrl;

    localparam int TIMEOUT = 1500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pie_cmd_if bus();

    pie_cmd_ctrl #(.TIMEOUT(TIMEOUT), .BUF_W(40)) dut (
        .clk_1_92m(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #260 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int last_cyc = 0;
    logic err_den = 1'b1;
    logic [8:0] m_tpri = '0;
    logic m_dr = 1'b0;
    int trcal_v = 0;

    always @(posedge clk) begin
        if (bus.cmd_valid) valid_cnt++;
        if (bus.cmd_err) begin
            err_cnt++;
            err_cyc = cyc;
            err_den = bus.dec_en;
        end
        cyc++;
    end

    // Reference: EPC Gen2 command table; b[0] is the first bit on air
    function automatic void ref_cmd(input logic [0:39] b, input logic crc,
                                    output int res_at, output int len,
                                    output bit err, output bit query);
        err = 0;
        query = 0;
        len = 0;
        if (!b[0]) begin
            res_at = 2;
            len = b[1] ? 18 : 4;
        end else if (!b[1]) begin
            res_at = 4;
            if (b[2]) err = 1;
            else begin
                len = b[3] ? 9 : 22;
                query = !b[3];
            end
        end else begin
            res_at = 8;
            if (b[2:6] != 5'd0) err = 1;
            else len = b[7] ? 40 : 8;
        end
        if (!err && (query != bit'(crc))) err = 1;
    endfunction

    task automatic send_delim();
        @(negedge clk);
        bus.delimiter = 1'b1;
        #20 bus.delimiter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_both(input logic d);
        @(negedge clk);
        bus.pie_data = d;
        #5;
        bus.delimiter = 1'b1;
        bus.pie_clk = 1'b1;
        #20;
        bus.delimiter = 1'b0;
        bus.pie_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bit(input logic d);
        @(negedge clk);
        last_cyc = cyc;
        bus.pie_data = d;
        #5 bus.pie_clk = 1'b1;
        #20 bus.pie_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.dec_done = 1'b1;
        repeat (3) @(negedge clk);
        bus.dec_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic [0:39] b, input logic crc,
                             input string tag);
        int res_at, len, nsend, e0, v0;
        bit err, query;
        logic [39:0] xbuf;
        ref_cmd(b, crc, res_at, len, err, query);
        nsend = err ? res_at : len;
        bus.crc_flg = crc;
        send_delim();
        n_cmp++;
        if (bus.cmd_len !== 6'd0 || bus.cmd_buf !== 40'd0) begin
            n_bad++;
            $display("FAIL %s clear: len=%0d buf=%h want 0", tag,
                     bus.cmd_len, bus.cmd_buf);
        end
        e0 = err_cnt;
        v0 = valid_cnt;
        xbuf = '0;
        for (int i = 0; i < nsend; i++) begin
            send_bit(b[i]);
            xbuf = {xbuf[38:0], b[i]};
            if (i + 1 == res_at) begin
                n_cmp++;
                if (bus.cmd_len !== 6'(len)) begin
                    n_bad++;
                    $display("FAIL %s len@%0d: got %0d want %0d", tag,
                             i + 1, bus.cmd_len, len);
                end
            end
            if (!err) begin
                n_cmp++;
                if (bus.cmd_end !== 1'(i + 1 == len)) begin
                    n_bad++;
                    $display("FAIL %s cmd_end@%0d: got %b", tag, i + 1,
                             bus.cmd_end);
                end
            end
        end
        if (err) begin
            n_cmp++;
            if (err_cnt !== e0 + 1 || valid_cnt !== v0 || err_den !== 1'b0) begin
                n_bad++;
                $display("FAIL %s err: errs=%0d valids=%0d den=%b want 1/0/0",
                         tag, err_cnt - e0, valid_cnt - v0, err_den);
            end
            n_cmp++;
            if (bus.tpri_10 !== m_tpri || bus.query_dr !== m_dr
                || bus.dec_en !== 1'b1) begin
                n_bad++;
                $display("FAIL %s hold: tpri=%0d dr=%b den=%b want %0d %b 1",
                         tag, bus.tpri_10, bus.query_dr, bus.dec_en,
                         m_tpri, m_dr);
            end
        end else begin
            pulse_done();
            if (query) begin
                m_dr = b[4];
                m_tpri = 9'((trcal_v * (m_dr ? 19 : 51)) / 4096);
            end
            n_cmp++;
            if (valid_cnt !== v0 + 1 || err_cnt !== e0) begin
                n_bad++;
                $display("FAIL %s valid: valids=%0d errs=%0d want 1/0", tag,
                         valid_cnt - v0, err_cnt - e0);
            end
            n_cmp++;
            if (bus.cmd_buf !== xbuf || bus.cmd_len !== 6'(len)) begin
                n_bad++;
                $display("FAIL %s buf: got %h/%0d want %h/%0d", tag,
                         bus.cmd_buf, bus.cmd_len, xbuf, len);
            end
            n_cmp++;
            if (bus.tpri_10 !== m_tpri || bus.query_dr !== m_dr) begin
                n_bad++;
                $display("FAIL %s tpri: got %0d/%b want %0d/%b", tag,
                         bus.tpri_10, bus.query_dr, m_tpri, m_dr);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #300;
        n_cmp++;
        if ({bus.dec_en, bus.cmd_end, bus.tpri_10, bus.query_dr, bus.cmd_buf,
             bus.cmd_len, bus.cmd_valid, bus.cmd_err} !== '0) begin
            n_bad++;
            $display("FAIL reset: outputs not zero (buf=%h len=%0d en=%b)",
                     bus.cmd_buf, bus.cmd_len, bus.dec_en);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.rx_en = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.dec_en !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_dec_en: got %b want 1", bus.dec_en);
        end
    endtask

    task automatic test_queryrep();
        run_frame(40'b0011 << 36, 1'b0, "queryrep");
    endtask

    task automatic test_query();
        logic [0:39] b;
        trcal_v = 640;
        bus.trcal = 10'd640;
        b = {$urandom(), 8'($urandom())};
        b[0:4] = 5'b10000;
        run_frame(b, 1'b1, "query_dr0");
        n_cmp++;
        if (bus.tpri_10 !== 9'd7 || bus.query_dr !== 1'b0) begin
            n_bad++;
            $display("FAIL query_dr0 const: got %0d/%b want 7/0",
                     bus.tpri_10, bus.query_dr);
        end
        b[4] = 1'b1;
        run_frame(b, 1'b1, "query_dr1");
        n_cmp++;
        if (bus.tpri_10 !== 9'd2 || bus.query_dr !== 1'b1) begin
            n_bad++;
            $display("FAIL query_dr1 const: got %0d/%b want 2/1",
                     bus.tpri_10, bus.query_dr);
        end
        run_frame(40'b1000 << 36, 1'b0, "query_nocrc");
        run_frame(40'b1010 << 36, 1'b0, "code_101x");
        run_frame(40'b11110000 << 32, 1'b0, "code_11xx");
        run_frame(40'b11000000 << 32, 1'b1, "nak_crc");
    endtask

    task automatic test_timeout(input bit in_end);
        int e0, c0;
        logic [0:39] b;
        bus.crc_flg = 1'b0;
        send_delim();
        b = {$urandom(), 8'($urandom())};
        b[0:1] = in_end ? 2'b00 : 2'b01;
        for (int i = 0; i < (in_end ? 4 : 10); i++) send_bit(b[i]);
        c0 = last_cyc;
        e0 = err_cnt;
        for (int k = 0; k < TIMEOUT + 20 && err_cnt == e0; k++)
            @(negedge clk);
        n_cmp++;
        if (err_cnt !== e0 + 1) begin
            n_bad++;
            $display("FAIL timeout%0d: no cmd_err within bound", in_end);
        end else begin
            // the bit event shows up two clock edges after the strobe
            n_cmp++;
            if (err_cyc - c0 !== TIMEOUT + 2) begin
                n_bad++;
                $display("FAIL timeout%0d delay: got %0d want %0d", in_end,
                         err_cyc - c0, TIMEOUT + 2);
            end
        end
        run_frame(40'b0010 << 36, 1'b0, "after_timeout");
    endtask

    task automatic test_end_bit();
        int e0;
        bus.crc_flg = 1'b0;
        send_delim();
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        e0 = err_cnt;
        send_bit(1'b1);
        n_cmp++;
        if (err_cnt !== e0 + 1) begin
            n_bad++;
            $display("FAIL end_bit: errs=%0d want 1", err_cnt - e0);
        end
    endtask

    task automatic test_abort();
        int e0, v0;
        bus.crc_flg = 1'b0;
        send_delim();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        e0 = err_cnt;
        v0 = valid_cnt;
        send_both(1'b1);
        n_cmp++;
        if (bus.cmd_len !== 6'd0 || bus.cmd_buf !== 40'd0 || err_cnt !== e0) begin
            n_bad++;
            $display("FAIL abort: len=%0d buf=%h errs=%0d want 0/0/0",
                     bus.cmd_len, bus.cmd_buf, err_cnt - e0);
        end
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        pulse_done();
        n_cmp++;
        if (valid_cnt !== v0 + 1 || bus.cmd_len !== 6'd4
            || bus.cmd_buf !== 40'h3) begin
            n_bad++;
            $display("FAIL abort_frame: valids=%0d len=%0d buf=%h want 1/4/3",
                     valid_cnt - v0, bus.cmd_len, bus.cmd_buf);
        end
    endtask

    task automatic test_rx_en_drop();
        int v0;
        bus.crc_flg = 1'b0;
        send_delim();
        v0 = valid_cnt;
        send_bit(1'b0); send_bit(1'b0);
        bus.rx_en = 1'b0;
        send_bit(1'b1); send_bit(1'b0);
        pulse_done();
        n_cmp++;
        if (valid_cnt !== v0 + 1 || bus.dec_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_en_drop: valids=%0d den=%b want 1/0",
                     valid_cnt - v0, bus.dec_en);
        end
        send_delim();
        send_bit(1'b1);
        n_cmp++;
        if (bus.dec_en !== 1'b0 || bus.cmd_len !== 6'd4
            || bus.cmd_buf !== 40'h2) begin
            n_bad++;
            $display("FAIL idle_ignore: den=%b len=%0d buf=%h want 0/4/2",
                     bus.dec_en, bus.cmd_len, bus.cmd_buf);
        end
        bus.rx_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [0:39] b;
        bus.crc_flg = 1'b0;
        send_delim();
        b = {$urandom(), 8'($urandom())};
        b[0:7] = 8'b11000001;
        for (int i = 0; i < 15; i++) send_bit(b[i]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dec_en, bus.cmd_end, bus.tpri_10, bus.query_dr, bus.cmd_buf,
             bus.cmd_len, bus.cmd_valid, bus.cmd_err} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: buf=%h len=%0d tpri=%0d want 0",
                     bus.cmd_buf, bus.cmd_len, bus.tpri_10);
        end
        m_tpri = '0;
        m_dr = 1'b0;
        #200 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(40'b11000000 << 32, 1'b0, "nak_after_rst");
    endtask

    task automatic test_random();
        logic [0:39] b;
        logic crc;
        int typ;
        for (int n = 0; n < 24; n++) begin
            b = {$urandom(), 8'($urandom())};
            typ = $urandom_range(0, 7);
            case (typ)
                0: b[0:1] = 2'b00;
                1: b[0:1] = 2'b01;
                2: b[0:3] = 4'b1000;
                3: b[0:3] = 4'b1001;
                4: b[0:7] = 8'b11000000;
                5: b[0:7] = 8'b11000001;
                6: b[0:2] = 3'b101;
                default: b[0:1] = 2'b11;
            endcase
            crc = (typ == 2);
            if ($urandom_range(0, 7) == 0) crc = !crc;
            trcal_v = $urandom_range(100, 1023);
            bus.trcal = 10'(trcal_v);
            run_frame(b, crc, $sformatf("rand%0d_t%0d", n, typ));
        end
    endtask

    initial begin
        bus.rx_en = 1'b0;
        bus.delimiter = 1'b0;
        bus.pie_clk = 1'b0;
        bus.pie_data = 1'b0;
        bus.crc_flg = 1'b0;
        bus.dec_done = 1'b0;
        bus.trcal = '0;
        test_reset();
        test_queryrep();
        test_query();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_end_bit();
        test_abort();
        test_rx_en_drop();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
